vga_timing_core: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA timing generator.
- Generates horizontal and vertical counters, sync, data-enable and frame/line markers for any VGA-style mode.
- Adds a configurable sync/DE delay line that aligns with a graphics pipeline of known latency, selectable sync polarity, a pixel clock-enable, generic input colour widths with MSB-replication expansion, and a frame counter.
- Sits between the graphics modules, which consume hc_out/vc_out and supply colour, and the 12-bit VGA pins.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_delay_line.sv | 34 +++
 rtl/vga_timing_core.sv | 135 +++++++++++++
 tb/tb_vga_timing_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA mode constants (640x480@60, 800x600@60) and colour-depth expansion.
// Pure package, no state.
package vga_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_H_POL    = 1'b0;
  localparam bit VGA640_V_POL    = 1'b0;

  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;
  localparam bit VGA800_H_POL    = 1'b1;
  localparam bit VGA800_V_POL    = 1'b1;

  // Fills 4 bits MSB-first by cycling through the w-bit value held in v[w-1:0].
  function automatic logic [3:0] expand_colour(input logic [3:0] v, input int w);
    logic [3:0] res;
    logic [1:0] idx;
    res = 4'h0;
    for (int i = 0; i < 4; i++) begin
      idx = 2'(w - 1 - (i % w));
      res[2'(3 - i)] = v[idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift register of DEPTH stages advancing on ce; DEPTH=0 is a wire.
// Latency DEPTH ce-ticks; no backpressure, ce=0 freezes every stage.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = ^{vgaclk, rst, ce};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge vgaclk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
      end else if (ce) begin
        r_stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA timing: raw counters/markers plus sync/DE delayed PIPE_STAGES ticks.
// Colour is combinational from inputs and delayed DE; no backpressure, ce gates all state.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = VGA640_H_ACTIVE,
  parameter int H_FP        = VGA640_H_FP,
  parameter int H_SYNC      = VGA640_H_SYNC,
  parameter int H_BP        = VGA640_H_BP,
  parameter int V_ACTIVE    = VGA640_V_ACTIVE,
  parameter int V_FP        = VGA640_V_FP,
  parameter int V_SYNC      = VGA640_V_SYNC,
  parameter int V_BP        = VGA640_V_BP,
  parameter bit H_POL       = VGA640_H_POL,
  parameter bit V_POL       = VGA640_V_POL,
  parameter int CNT_W       = 10,
  parameter int PIPE_STAGES = 0,
  parameter int R_W         = 3,
  parameter int G_W         = 3,
  parameter int B_W         = 2
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic             ce,
  input  logic [R_W-1:0]   input_red,
  input  logic [G_W-1:0]   input_green,
  input  logic [B_W-1:0]   input_blue,
  output logic [CNT_W-1:0] hc_out,
  output logic [CNT_W-1:0] vc_out,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (CNT_W < 1 || CNT_W > 31 || ((H_TOTAL - 1) >> CNT_W) != 0 ||
      ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("vga_timing_core: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
  end
  if (R_W < 1 || R_W > 4 || G_W < 1 || G_W > 4 || B_W < 1 || B_W > 4) begin : g_bad_col_w
    $error("vga_timing_core: colour widths must be 1..4");
  end
  if (PIPE_STAGES < 0 || PIPE_STAGES > 15) begin : g_bad_pipe
    $error("vga_timing_core: PIPE_STAGES must be 0..15");
  end

  // One extra bit so boundaries equal to 2**CNT_W stay representable.
  localparam logic [CNT_W:0]   H_TOT_C  = (CNT_W+1)'(H_TOTAL);
  localparam logic [CNT_W:0]   V_TOT_C  = (CNT_W+1)'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W:0]   H_ACT_C  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0]   V_ACT_C  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0]   HS_BEG_C = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0]   HS_END_C = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0]   VS_BEG_C = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0]   VS_END_C = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_hc;
  logic [CNT_W-1:0] r_vc;
  logic [15:0]      r_frame_count;

  logic [CNT_W:0] w_hc_x;
  logic [CNT_W:0] w_vc_x;
  logic           w_h_end;
  logic           w_v_end;
  logic           w_de_raw;
  logic           w_hsync_raw;
  logic           w_vsync_raw;
  logic [2:0]     w_dly;

  assign w_hc_x  = {1'b0, r_hc};
  assign w_vc_x  = {1'b0, r_vc};
  assign w_h_end = (r_hc == H_LAST) || (w_hc_x >= H_TOT_C);
  assign w_v_end = (r_vc == V_LAST) || (w_vc_x >= V_TOT_C);

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_frame_count <= '0;
    end else if (ce) begin
      if (w_h_end) begin
        r_hc <= '0;
        if (w_v_end) begin
          r_vc          <= '0;
          r_frame_count <= r_frame_count + 16'd1;
        end else begin
          r_vc <= r_vc + CNT_W'(1);
        end
      end else begin
        r_hc <= r_hc + CNT_W'(1);
      end
    end
  end

  assign w_de_raw    = (w_hc_x < H_ACT_C) && (w_vc_x < V_ACT_C);
  assign w_hsync_raw = (w_hc_x >= HS_BEG_C && w_hc_x < HS_END_C) ? H_POL : ~H_POL;
  assign w_vsync_raw = (w_vc_x >= VS_BEG_C && w_vc_x < VS_END_C) ? V_POL : ~V_POL;

  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_STAGES),
    .RESET_VAL ({~H_POL, ~V_POL, 1'b0})
  ) u_sync_dly (
    .vgaclk (vgaclk),
    .rst    (rst),
    .ce     (ce),
    .d      ({w_hsync_raw, w_vsync_raw, w_de_raw}),
    .q      (w_dly)
  );

  assign hsync = w_dly[2];
  assign vsync = w_dly[1];
  assign de    = w_dly[0];

  assign hc_out      = r_hc;
  assign vc_out      = r_vc;
  assign frame_count = r_frame_count;
  assign line_start  = (r_hc == '0) && ce;
  assign frame_start = (r_hc == '0) && (r_vc == '0) && ce;

  assign red   = de ? expand_colour(4'(input_red),   R_W) : 4'h0;
  assign green = de ? expand_colour(4'(input_green), G_W) : 4'h0;
  assign blue  = de ? expand_colour(4'(input_blue),  B_W) : 4'h0;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core on a reduced 15x8 mode with a 2-stage delay line,
// active-high hsync and active-low vsync.
module tb_vga_timing_core;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int P  = 2;

  logic       vgaclk;
  logic       rst;
  logic       ce;
  logic [2:0] input_red;
  logic [2:0] input_green;
  logic [1:0] input_blue;
  logic [3:0] hc_out;
  logic [3:0] vc_out;
  logic       line_start;
  logic       frame_start;
  logic [15:0] frame_count;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  int total;
  int bad;
  int t;
  bit model_ok;
  bit done;

  vga_timing_core #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b0), .CNT_W(4), .PIPE_STAGES(P),
    .R_W(3), .G_W(3), .B_W(2)
  ) dut (
    .vgaclk      (vgaclk),
    .rst         (rst),
    .ce          (ce),
    .input_red   (input_red),
    .input_green (input_green),
    .input_blue  (input_blue),
    .hc_out      (hc_out),
    .vc_out      (vc_out),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  initial vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Replicate the w-bit value four times and keep the top four bits.
  function automatic int expand_m(input int v, input int w);
    int rep;
    rep = 0;
    for (int i = 0; i < 4; i++) rep = (rep << w) | v;
    return (rep >> (4 * w - 4)) & 15;
  endfunction

  // Model state: number of ce ticks since the last reset.
  always @(posedge vgaclk) begin
    if (rst) begin
      t        <= 0;
      model_ok <= 1'b1;
    end else if (ce) begin
      t <= t + 1;
    end
  end

  always @(negedge vgaclk) begin
    if (model_ok && !done) begin
      int pos, h, v, m_hc, m_vc;
      bit m_de, m_hs, m_vs;
      m_hc = t % HT;
      m_vc = (t / HT) % VT;
      if (t < P) begin
        m_de = 1'b0; m_hs = 1'b0; m_vs = 1'b1;
      end else begin
        pos  = t - P;
        h    = pos % HT;
        v    = (pos / HT) % VT;
        m_de = (h < HA) && (v < VA);
        m_hs = (h >= HA + HF) && (h < HA + HF + HS);
        m_vs = !((v >= VA + VF) && (v < VA + VF + VS));
      end
      check("m_hc", 32'(hc_out), m_hc);
      check("m_vc", 32'(vc_out), m_vc);
      check("m_fcnt", 32'(frame_count), (t / FT) % 65536);
      check("m_line_start", 32'(line_start), int'(m_hc == 0 && ce == 1'b1));
      check("m_frame_start", 32'(frame_start), int'(m_hc == 0 && m_vc == 0 && ce == 1'b1));
      check("m_hsync", 32'(hsync), int'(m_hs));
      check("m_vsync", 32'(vsync), int'(m_vs));
      check("m_de", 32'(de), int'(m_de));
      check("m_red", 32'(red), m_de ? expand_m(int'(input_red), 3) : 0);
      check("m_green", 32'(green), m_de ? expand_m(int'(input_green), 3) : 0);
      check("m_blue", 32'(blue), m_de ? expand_m(int'(input_blue), 2) : 0);
    end
  end

  initial begin
    logic [14:0] hs_mask, de_mask;
    logic [7:0]  vs_mask;
    logic [11:0] col_act, col_blank;
    logic [3:0]  red_tail, prev_hc;
    int de_cnt, fs_n, chg;
    int fs_at [3];
    int fc_at [3];
    bit found;

    rst = 1'b1; ce = 1'b1;
    input_red = 3'b101; input_green = 3'b111; input_blue = 2'b01;
    @(posedge vgaclk);
    @(negedge vgaclk);
    check("rst_hc", 32'(hc_out), 0);
    check("rst_vc", 32'(vc_out), 0);
    check("rst_fcnt", 32'(frame_count), 0);
    check("rst_hsync", 32'(hsync), 0);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_de", 32'(de), 0);
    check("rst_red", 32'(red), 0);
    @(posedge vgaclk); #1 rst = 1'b0;

    // Two full frames with ce high and colour held.
    hs_mask = '0; de_mask = '0; vs_mask = '0;
    col_act = '1; col_blank = '1; red_tail = '0;
    de_cnt = 0; fs_n = 0;
    for (int cyc = 0; cyc < 250; cyc++) begin
      @(negedge vgaclk);
      if (frame_start) begin
        if (fs_n < 3) begin
          fs_at[fs_n] = cyc;
          fc_at[fs_n] = int'(frame_count);
        end
        fs_n++;
      end
      if (cyc < FT && de) de_cnt++;
      if (vc_out == 4'd1 && hsync) hs_mask[hc_out] = 1'b1;
      if (vc_out == 4'd1 && de) de_mask[hc_out] = 1'b1;
      if (cyc < FT && hc_out == 4'd5 && !vsync) vs_mask[vc_out[2:0]] = 1'b1;
      if (cyc < FT && vc_out == 4'd0 && hc_out == 4'd4) col_act = {red, green, blue};
      if (cyc < FT && vc_out == 4'd5 && hc_out == 4'd4) col_blank = {red, green, blue};
      if (cyc < FT && vc_out == 4'd2 && (hc_out == 4'd10 || hc_out == 4'd11)) red_tail |= red;
    end
    check("fs_count", 32'(fs_n), 3);
    check("fs_first", 32'(fs_at[0]), 0);
    check("fs_period_a", 32'(fs_at[1] - fs_at[0]), FT);
    check("fs_period_b", 32'(fs_at[2] - fs_at[1]), FT);
    check("fcnt_at_f1", 32'(fc_at[1]), 1);
    check("fcnt_at_f2", 32'(fc_at[2]), 2);
    check("hs_mask", 32'(hs_mask), 'h7000);
    check("de_mask", 32'(de_mask), 'h03FC);
    check("vs_low_lines", 32'(vs_mask), 'h60);
    check("de_per_frame", 32'(de_cnt), HA * VA);
    check("col_active", 32'(col_act), 'hBF5);
    check("col_blank", 32'(col_blank), 0);
    check("red_pipe_tail", 32'(red_tail), 0);

    // ce alternating: one tick per two cycles.
    @(posedge vgaclk); #1 rst = 1'b1;
    @(posedge vgaclk); #1 rst = 1'b0;
    fs_n = 0; chg = 0; prev_hc = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge vgaclk); #1;
      ce = ~ce;
      input_red   = 3'($urandom_range(0, 7));
      input_green = 3'($urandom_range(0, 7));
      input_blue  = 2'($urandom_range(0, 3));
      @(negedge vgaclk);
      if (cyc > 0 && cyc <= 480 && hc_out != prev_hc) chg++;
      prev_hc = hc_out;
      if (frame_start) begin
        if (fs_n < 2) fs_at[fs_n] = cyc;
        fs_n++;
      end
    end
    check("ce_hc_steps", 32'(chg), 240);
    check("ce_fs_seen", 32'(fs_n >= 2), 1);
    check("ce_fs_period", 32'(fs_at[1] - fs_at[0]), 2 * FT);

    // Reset in the middle of a frame.
    @(posedge vgaclk); #1;
    ce = 1'b1; input_red = 3'b011; input_green = 3'b010; input_blue = 2'b10;
    found = 1'b0;
    for (int cyc = 0; cyc < 300 && !found; cyc++) begin
      @(negedge vgaclk);
      if (vc_out == 4'd5 && hc_out == 4'd7) found = 1'b1;
    end
    check("reach_mid_frame", 32'(found), 1);
    @(posedge vgaclk); #1 rst = 1'b1;
    @(posedge vgaclk);
    @(negedge vgaclk);
    check("mid_rst_hc", 32'(hc_out), 0);
    check("mid_rst_vc", 32'(vc_out), 0);
    check("mid_rst_fcnt", 32'(frame_count), 0);
    check("mid_rst_de", 32'(de), 0);
    check("mid_rst_col", 32'({red, green, blue}), 0);
    @(posedge vgaclk); #1 rst = 1'b0;
    de_cnt = 0; fs_n = 0;
    for (int cyc = 0; cyc <= FT; cyc++) begin
      @(negedge vgaclk);
      if (cyc < FT && de) de_cnt++;
      if (frame_start) begin
        if (fs_n < 2) fs_at[fs_n] = cyc;
        fs_n++;
      end
    end
    check("rr_de_per_frame", 32'(de_cnt), HA * VA);
    check("rr_fs_count", 32'(fs_n), 2);
    check("rr_fs_first", 32'(fs_at[0]), 0);
    check("rr_fs_period", 32'(fs_at[1] - fs_at[0]), FT);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
